// File: rtl/freq_pkg.sv
// ----------------------------------------------------------------------------
// freq_pkg
// Shared definitions for the frequency-counter gate sequencer.
//   state_t      : sequencer state encoding (also exported as a debug output)
//   RNG_*        : gate-range codes; the code doubles as the decimal-point position
//   TIMER_W      : width of the gate/phase down-counter (holds 100e6 - 1)
//   gate_cycles  : gate length in system clocks for a given range
// ----------------------------------------------------------------------------
package freq_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        ARM    = 3'd1,
        GATE   = 3'd2,
        SETTLE = 3'd3,
        LATCH  = 3'd4,
        DONE   = 3'd5
    } state_t;

    localparam logic [1:0] RNG_1S    = 2'd0;
    localparam logic [1:0] RNG_100MS = 2'd1;
    localparam logic [1:0] RNG_10MS  = 2'd2;

    localparam int TIMER_W = 27;

    // CLK_HZ / 10**rng. clk_hz is a multiple of 100, so every range divides exactly.
    function automatic logic [TIMER_W-1:0] gate_cycles(input logic [1:0]  rng,
                                                       input int unsigned clk_hz);
        int unsigned cyc;
        case (rng)
            RNG_100MS: cyc = clk_hz / 10;
            RNG_10MS:  cyc = clk_hz / 100;
            default:   cyc = clk_hz;
        endcase
        return cyc[TIMER_W-1:0];
    endfunction

endpackage

// File: rtl/gate_timer.sv
// ----------------------------------------------------------------------------
// gate_timer
// Loadable down-counter that times every sequencer phase (ARM, GATE, SETTLE,
// LATCH). A phase of N cycles is timed by loading N-1 on phase entry; the phase
// ends on the cycle where zero is high. The counter parks at zero when idle.
// Ports:
//   clk      in   system clock
//   reset    in   asynchronous, active-low
//   load     in   load load_val this cycle (takes priority over counting)
//   load_val in   W-bit value to load
//   zero     out  count == 0
// ----------------------------------------------------------------------------
module gate_timer
    import freq_pkg::*;
#(
    parameter int W = TIMER_W
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         zero
);

    logic [W-1:0] count;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (count != '0) begin
            count <= count - 1'b1;
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/freq_gate_ctrl.sv
// ----------------------------------------------------------------------------
// freq_gate_ctrl
// Measurement sequencer for a BCD frequency-counter chain. Opens a timed gate
// window, lets the chain settle, then pulses the chain's active-low reset so
// each digit latches its count into its output buffer and clears. Captures
// overflow from the top digit's carry during the window.
//
// Optional feature (macro AUTORANGE_EN): after each measurement the gate range
// steps shorter on overflow and longer when the top buffered digit is zero.
// Without the macro the range is fixed at 1 s and msd_zero is ignored.
//
// Ports:
//   clk        in   system clock
//   reset      in   asynchronous, active-low
//   run        in   1 = measure continuously, 0 = stop/abort
//   ovf_in     in   top-digit carry (asynchronous, >= 1 clk wide)
//   msd_zero   in   most-significant buffered digit is zero (autorange only)
//   gate       out  counting window enable to the digit chain
//   cnt_rst_n  out  active-low latch+clear strobe to the digit chain
//   meas_valid out  one-cycle pulse: new buffered result available
//   overflow   out  last completed measurement overflowed
//   range      out  0 = 1 s, 1 = 100 ms, 2 = 10 ms gate (decimal-point position)
//   state_dbg  out  current sequencer state
//
// Handshake: there is no back-pressure. meas_valid is a single-cycle strobe in
// DONE; overflow and range are stable from that cycle until the next DONE.
// ----------------------------------------------------------------------------
module freq_gate_ctrl
    import freq_pkg::*;
#(
    parameter int unsigned CLK_HZ        = 100_000_000,
    parameter int unsigned SETTLE_CYCLES = 4,
    parameter int unsigned CLR_CYCLES    = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       run,
    input  logic       ovf_in,
    input  logic       msd_zero,
    output logic       gate,
    output logic       cnt_rst_n,
    output logic       meas_valid,
    output logic       overflow,
    output logic [1:0] range,
    output state_t     state_dbg
);

    localparam logic [TIMER_W-1:0] CLR_LOAD    = TIMER_W'(CLR_CYCLES - 1);
    localparam logic [TIMER_W-1:0] SETTLE_LOAD = TIMER_W'(SETTLE_CYCLES - 1);

    state_t               state;
    logic                 ovf_sticky;
    logic [2:0]           ovf_sync;
    logic                 ovf_edge;
    logic                 tmr_load;
    logic [TIMER_W-1:0]   tmr_val;
    logic                 tmr_zero;
    logic [TIMER_W-1:0]   gate_load;

`ifndef AUTORANGE_EN
    logic unused_msd_zero;
    assign unused_msd_zero = msd_zero;
`endif

    assign state_dbg = state;

    // ovf_sync[1:0] is the two-flop synchronizer; ovf_sync[2] is the delayed copy
    // used for rising-edge detection.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ovf_sync <= '0;
        end else begin
            ovf_sync <= {ovf_sync[1:0], ovf_in};
        end
    end

    assign ovf_edge = ovf_sync[1] & ~ovf_sync[2];

    // range is already updated by the time DONE reloads the timer, so the new
    // range takes effect on the very next gate window.
    assign gate_load = gate_cycles(range, CLK_HZ) - 1'b1;

    // Timer reload happens exactly on the cycle the FSM leaves a state, loading
    // the length of the state being entered. LATCH->DONE needs no load: DONE is
    // always a single cycle.
    always_comb begin
        tmr_load = 1'b0;
        tmr_val  = '0;
        case (state)
            IDLE: begin
                if (run) begin
                    tmr_load = 1'b1;
                    tmr_val  = CLR_LOAD;
                end
            end
            ARM: begin
                if (run && tmr_zero) begin
                    tmr_load = 1'b1;
                    tmr_val  = gate_load;
                end
            end
            GATE: begin
                if (run && tmr_zero) begin
                    tmr_load = 1'b1;
                    tmr_val  = SETTLE_LOAD;
                end
            end
            SETTLE: begin
                if (run && tmr_zero) begin
                    tmr_load = 1'b1;
                    tmr_val  = CLR_LOAD;
                end
            end
            DONE: begin
                if (run) begin
                    tmr_load = 1'b1;
                    tmr_val  = gate_load;
                end
            end
            default: begin
                tmr_load = 1'b0;
                tmr_val  = '0;
            end
        endcase
    end

    gate_timer #(
        .W (TIMER_W)
    ) u_timer (
        .clk      (clk),
        .reset    (reset),
        .load     (tmr_load),
        .load_val (tmr_val),
        .zero     (tmr_zero)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            gate       <= 1'b0;
            cnt_rst_n  <= 1'b1;
            meas_valid <= 1'b0;
            overflow   <= 1'b0;
            range      <= RNG_1S;
            ovf_sticky <= 1'b0;
        end else begin
            meas_valid <= 1'b0;
            case (state)
                IDLE: begin
                    gate      <= 1'b0;
                    cnt_rst_n <= 1'b1;
                    if (run) begin
                        state     <= ARM;
                        cnt_rst_n <= 1'b0;
                    end
                end
                ARM: begin
                    if (!run) begin
                        state     <= IDLE;
                        gate      <= 1'b0;
                        cnt_rst_n <= 1'b1;
                    end else if (tmr_zero) begin
                        state      <= GATE;
                        cnt_rst_n  <= 1'b1;
                        gate       <= 1'b1;
                        ovf_sticky <= 1'b0;
                    end
                end
                GATE: begin
                    if (!run) begin
                        state     <= IDLE;
                        gate      <= 1'b0;
                        cnt_rst_n <= 1'b1;
                    end else begin
                        if (ovf_edge) begin
                            ovf_sticky <= 1'b1;
                        end
                        if (tmr_zero) begin
                            state <= SETTLE;
                            gate  <= 1'b0;
                        end
                    end
                end
                SETTLE: begin
                    if (!run) begin
                        state     <= IDLE;
                        gate      <= 1'b0;
                        cnt_rst_n <= 1'b1;
                    end else begin
                        // A carry still rippling out of the last gate cycle lands here.
                        if (ovf_edge) begin
                            ovf_sticky <= 1'b1;
                        end
                        if (tmr_zero) begin
                            state     <= LATCH;
                            cnt_rst_n <= 1'b0;
                        end
                    end
                end
                LATCH: begin
                    // Not abortable: the chain must finish latching and clearing.
                    if (tmr_zero) begin
                        state      <= DONE;
                        cnt_rst_n  <= 1'b1;
                        meas_valid <= 1'b1;
                        overflow   <= ovf_sticky;
`ifdef AUTORANGE_EN
                        if (ovf_sticky && (range < RNG_10MS)) begin
                            range <= range + 2'd1;
                        end else if (!ovf_sticky && msd_zero && (range > RNG_1S)) begin
                            range <= range - 2'd1;
                        end
`endif
                    end
                end
                DONE: begin
                    // LATCH already cleared the chain, so a continuous run skips ARM.
                    if (run) begin
                        state      <= GATE;
                        gate       <= 1'b1;
                        ovf_sticky <= 1'b0;
                    end else begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state     <= IDLE;
                    gate      <= 1'b0;
                    cnt_rst_n <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_freq_gate_ctrl.sv
// ----------------------------------------------------------------------------
// tb_freq_gate_ctrl
// Directed bench for freq_gate_ctrl at CLK_HZ=1000, SETTLE_CYCLES=4,
// CLR_CYCLES=2. Phase lengths are measured at the falling edge and compared
// with hand-computed values; expected gate lengths are queued per measurement.
// Build with +define+AUTORANGE_EN to also exercise range stepping.
// ----------------------------------------------------------------------------
module tb_freq_gate_ctrl;
    import freq_pkg::*;

    localparam int S_GATE  = 0;
    localparam int S_CNT   = 1;
    localparam int S_VALID = 2;

    logic       clk;
    logic       reset;
    logic       run;
    logic       ovf_in;
    logic       msd_zero;
    logic       gate;
    logic       cnt_rst_n;
    logic       meas_valid;
    logic       overflow;
    logic [1:0] range;
    state_t     state_dbg;

    int          n_vec;
    int          n_err;
    int          cyc;
    int          last_gate_start;
    logic [31:0] exp_q[$];

    freq_gate_ctrl #(
        .CLK_HZ        (1000),
        .SETTLE_CYCLES (4),
        .CLR_CYCLES    (2)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .run        (run),
        .ovf_in     (ovf_in),
        .msd_zero   (msd_zero),
        .gate       (gate),
        .cnt_rst_n  (cnt_rst_n),
        .meas_valid (meas_valid),
        .overflow   (overflow),
        .range      (range),
        .state_dbg  (state_dbg)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic logic sig_sel(input int s);
        case (s)
            S_GATE:  return gate;
            S_CNT:   return cnt_rst_n;
            default: return meas_valid;
        endcase
    endfunction

    // Counts consecutive falling-edge samples where the selected signal equals
    // val; returns on the first sample that differs (or when budget runs out).
    task automatic count_while(input int sel, input logic val, input int budget, output int n);
        n = 0;
        while ((sig_sel(sel) === val) && (n < budget)) begin
            n++;
            @(negedge clk);
        end
    endtask

    // One full measurement, starting at a falling edge where the DUT is either
    // in IDLE (from_idle) or in its first GATE cycle (back-to-back).
    task automatic measure(input bit from_idle, input int ovf_at, input logic exp_ovf,
                           input logic [1:0] exp_rng, input bit drop_in_latch);
        int n;
        logic [31:0] exp_gate;
        exp_gate = exp_q.pop_front();
        if (from_idle) begin
            count_while(S_CNT, 1'b1, 20, n);
            check("idle_lead", n, 1);
            count_while(S_CNT, 1'b0, 20, n);
            check("arm_len", n, 2);
        end else begin
            check("b2b_no_arm", cnt_rst_n, 1);
        end
        last_gate_start = cyc;
        n = 0;
        while ((gate === 1'b1) && (n < int'(exp_gate) + 5)) begin
            ovf_in = (n == ovf_at);
            n++;
            @(negedge clk);
        end
        ovf_in = 1'b0;
        check("gate_len", n, exp_gate);
        count_while(S_CNT, 1'b1, 20, n);
        check("settle_len", n, 4);
        if (drop_in_latch) run = 1'b0;
        count_while(S_CNT, 1'b0, 20, n);
        check("latch_len", n, 2);
        check("valid_hi", meas_valid, 1);
        check("ovf_at_valid", overflow, exp_ovf);
        check("range_at_valid", range, exp_rng);
        count_while(S_VALID, 1'b1, 20, n);
        check("valid_len", n, 1);
        if (!run) begin
            check("stop_idle", state_dbg, IDLE);
            check("stop_gate", gate, 0);
        end
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int n;
        int prev_start;
        int vcnt;
        bit found;

        n_vec    = 0;
        n_err    = 0;
        cyc      = 0;
        reset    = 1'b0;
        run      = 1'b1;
        ovf_in   = 1'b0;
        msd_zero = 1'b0;

        // Reset held with run=1: everything at reset values.
        repeat (3) @(negedge clk);
        check("rst_gate", gate, 0);
        check("rst_cnt_rst_n", cnt_rst_n, 1);
        check("rst_valid", meas_valid, 0);
        check("rst_overflow", overflow, 0);
        check("rst_range", range, 0);
        check("rst_state", state_dbg, IDLE);

        // Release: first measurement, clean.
        reset = 1'b1;
        exp_q.push_back(1000);
        measure(1'b1, -1, 1'b0, 2'd0, 1'b0);

        // Back-to-back with an overflow pulse mid-gate; check the period.
        prev_start = last_gate_start;
        exp_q.push_back(1000);
        measure(1'b0, 300, 1'b1, 2'd0, 1'b0);
        check("period", last_gate_start - prev_start, 1007);

        // Next clean measurement clears overflow.
        exp_q.push_back(1000);
        measure(1'b0, -1, 1'b0, 2'd0, 1'b0);

        // Overflow again, run dropped during LATCH: latch completes, then IDLE.
        exp_q.push_back(1000);
        measure(1'b0, 500, 1'b1, 2'd0, 1'b1);

        // ovf_in pulse in IDLE: no effect.
        ovf_in = 1'b1;
        @(negedge clk);
        ovf_in = 1'b0;
        repeat (6) @(negedge clk);
        check("idle_ovf_state", state_dbg, IDLE);
        check("idle_ovf_overflow", overflow, 1);

        // Abort at gate cycle 500.
        run = 1'b1;
        count_while(S_CNT, 1'b1, 20, n);
        check("abort_lead", n, 1);
        count_while(S_CNT, 1'b0, 20, n);
        check("abort_arm_len", n, 2);
        count_while(S_GATE, 1'b1, 500, n);
        check("abort_gate_open", n, 500);
        run = 1'b0;
        @(negedge clk);
        check("abort_gate", gate, 0);
        check("abort_cnt_rst_n", cnt_rst_n, 1);
        check("abort_state", state_dbg, IDLE);
        check("abort_overflow", overflow, 1);
        vcnt = 0;
        repeat (1100) begin
            if (meas_valid === 1'b1) vcnt++;
            @(negedge clk);
        end
        check("abort_no_valid", vcnt, 0);

`ifdef AUTORANGE_EN
        // Range steps: 1 s -> 100 ms -> 10 ms, saturates, then back to 100 ms.
        run = 1'b1;
        exp_q.push_back(1000);
        measure(1'b1, 300, 1'b1, 2'd1, 1'b0);
        exp_q.push_back(100);
        measure(1'b0, 30, 1'b1, 2'd2, 1'b0);
        exp_q.push_back(10);
        measure(1'b0, 3, 1'b1, 2'd2, 1'b0);
        msd_zero = 1'b1;
        exp_q.push_back(10);
        measure(1'b0, -1, 1'b0, 2'd1, 1'b0);
        msd_zero = 1'b0;
        exp_q.push_back(100);
        measure(1'b0, -1, 1'b0, 2'd1, 1'b1);
`endif

        // Async reset while in LATCH.
        run   = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            if (state_dbg == LATCH) begin
                found = 1'b1;
                break;
            end
            @(negedge clk);
        end
        check("reach_latch", found, 1);
        #2 reset = 1'b0;
        #1;
        check("latch_rst_cnt_rst_n", cnt_rst_n, 1);
        check("latch_rst_gate", gate, 0);
        check("latch_rst_range", range, 0);
        check("latch_rst_valid", meas_valid, 0);
        check("latch_rst_state", state_dbg, IDLE);
        run = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
